// File: rtl/rv32_ctrl_pkg.sv
// Shared constants for the RV32I multicycle control unit: opcodes, ALU ops,
// writeback selects, FSM states and the decoded control vector.
package rv32_ctrl_pkg;

    localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
    localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
    localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
    localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
    localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
    localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
    localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
    localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
    localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b1000;
    localparam logic [3:0] SLL  = 4'b0001;
    localparam logic [3:0] SLT  = 4'b0010;
    localparam logic [3:0] SLTU = 4'b0011;
    localparam logic [3:0] XOR  = 4'b0100;
    localparam logic [3:0] SRL  = 4'b0101;
    localparam logic [3:0] SRA  = 4'b1101;
    localparam logic [3:0] OR   = 4'b0110;
    localparam logic [3:0] AND  = 4'b0111;

    localparam logic [2:0] RFWD_ALU   = 3'd0;
    localparam logic [2:0] RFWD_BUS   = 3'd1;
    localparam logic [2:0] RFWD_IMM   = 3'd2;
    localparam logic [2:0] RFWD_PCIMM = 3'd3;
    localparam logic [2:0] RFWD_PC4   = 3'd4;

    typedef enum logic [3:0] {
        FETCH, DECODE,
        R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE,
        L_EXE, S_EXE, L_MEM, S_MEM, L_WB,
        ILL
    } ctrl_state_e;

    typedef struct packed {
        logic       pc_en;
        logic       rf_we;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic [2:0] rfwd_sel;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       bus_req;
        logic       bus_we;
        logic [2:0] bus_size;
        logic       illegal;
    } ctrl_out_t;

endpackage

// File: rtl/rv32_ctrl_decode.sv
// Moore output decode: FSM state plus instruction fields to the control vector.
// CU_ILLEGAL_TRAP_EN makes the ILL state raise the illegal flag.
module rv32_ctrl_decode
    import rv32_ctrl_pkg::*;
(
    input  ctrl_state_e state,
    input  logic [2:0]  funct3,
    input  logic        instr_b30,
    output ctrl_out_t   ctrl
);

    always_comb begin
        ctrl = '0;
        ctrl.alu_ctrl = ADD;
        ctrl.rfwd_sel = RFWD_ALU;
        case (state)
            FETCH: ctrl.pc_en = 1'b1;
            R_EXE: begin
                ctrl.alu_ctrl = {instr_b30, funct3};
                ctrl.rf_we    = 1'b1;
            end
            I_EXE: begin
                ctrl.alu_src  = 1'b1;
                // bit 30 of an I-type is immediate data except for SRAI/SRLI
                ctrl.alu_ctrl = (funct3 == 3'b101) ? {instr_b30, funct3} : {1'b0, funct3};
                ctrl.rf_we    = 1'b1;
            end
            B_EXE: begin
                ctrl.alu_ctrl = {1'b0, funct3};
                ctrl.branch   = 1'b1;
            end
            LU_EXE: begin
                ctrl.rfwd_sel = RFWD_IMM;
                ctrl.rf_we    = 1'b1;
            end
            AU_EXE: begin
                ctrl.rfwd_sel = RFWD_PCIMM;
                ctrl.rf_we    = 1'b1;
            end
            J_EXE: begin
                ctrl.jal      = 1'b1;
                ctrl.rfwd_sel = RFWD_PC4;
                ctrl.rf_we    = 1'b1;
            end
            JL_EXE: begin
                ctrl.jal      = 1'b1;
                ctrl.jalr     = 1'b1;
                ctrl.rfwd_sel = RFWD_PC4;
                ctrl.rf_we    = 1'b1;
            end
            L_EXE, S_EXE: ctrl.alu_src = 1'b1;
            L_MEM: begin
                ctrl.bus_req  = 1'b1;
                ctrl.bus_size = funct3;
            end
            S_MEM: begin
                ctrl.bus_req  = 1'b1;
                ctrl.bus_we   = 1'b1;
                ctrl.bus_size = funct3;
            end
            L_WB: begin
                ctrl.rfwd_sel = RFWD_BUS;
                ctrl.rf_we    = 1'b1;
            end
            ILL: begin
`ifdef CU_ILLEGAL_TRAP_EN
                ctrl.illegal = 1'b1;
`else
                ctrl.illegal = 1'b0;
`endif
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// RV32I multicycle control FSM with data-bus handshake and wait timeout.
// Define CU_ILLEGAL_TRAP_EN to make illegal opcodes a terminal trap.
module rv32_multicycle_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int BUS_WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    output logic        PCEn,
    output logic        regFileWe,
    output logic        aluSrcMuxSel,
    output logic [3:0]  aluControl,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        busReq,
    output logic        busWe,
    output logic [2:0]  busSize,
    input  logic        busReady,
    output logic        busErr,
    output logic        illegal
);

    localparam int CNT_W = (BUS_WAIT_MAX > 1) ? $clog2(BUS_WAIT_MAX + 1) : 1;

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             in_mem;
    logic             timeout;
    ctrl_out_t        dec;
    logic [6:0]       opcode;
    logic             unused_instr_bits;

    assign opcode = instrCode[6:0];
    // Operand/immediate fields belong to the datapath, not the controller
    assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    assign in_mem  = (state_q == L_MEM) || (state_q == S_MEM);
    assign timeout = (BUS_WAIT_MAX > 0) && in_mem && !busReady
                     && (wait_cnt_q == CNT_W'(BUS_WAIT_MAX - 1));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_TYPE_R:  state_d = R_EXE;
                    OP_TYPE_I:  state_d = I_EXE;
                    OP_TYPE_B:  state_d = B_EXE;
                    OP_TYPE_L:  state_d = L_EXE;
                    OP_TYPE_S:  state_d = S_EXE;
                    OP_TYPE_LU: state_d = LU_EXE;
                    OP_TYPE_AU: state_d = AU_EXE;
                    OP_TYPE_J:  state_d = J_EXE;
                    OP_TYPE_JL: state_d = JL_EXE;
                    default:    state_d = ILL;
                endcase
            end
            L_EXE: state_d = L_MEM;
            S_EXE: state_d = S_MEM;
            L_MEM, S_MEM: begin
                // busReady in the timeout cycle still counts as completion
                if (busReady)
                    state_d = (state_q == L_MEM) ? L_WB : FETCH;
                else if (timeout)
                    state_d = FETCH;
                else
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
            ILL: begin
`ifdef CU_ILLEGAL_TRAP_EN
                state_d = ILL;
`else
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    rv32_ctrl_decode u_decode (
        .state     (state_q),
        .funct3    (instrCode[14:12]),
        .instr_b30 (instrCode[30]),
        .ctrl      (dec)
    );

    // Gating by reset drops every request immediately, even mid-transfer
    assign PCEn          = !reset && dec.pc_en;
    assign regFileWe     = !reset && dec.rf_we;
    assign aluSrcMuxSel  = !reset && dec.alu_src;
    assign aluControl    = reset ? ADD : dec.alu_ctrl;
    assign RFWDSrcMuxSel = reset ? RFWD_ALU : dec.rfwd_sel;
    assign branch        = !reset && dec.branch;
    assign jal           = !reset && dec.jal;
    assign jalr          = !reset && dec.jalr;
    assign busReq        = !reset && dec.bus_req;
    assign busWe         = !reset && dec.bus_we;
    assign busSize       = reset ? 3'b000 : dec.bus_size;
    assign busErr        = !reset && timeout;
    assign illegal       = !reset && dec.illegal;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed bench for rv32_multicycle_ctrl (BUS_WAIT_MAX=4); honours CU_ILLEGAL_TRAP_EN.
module tb_rv32_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrCode;
    logic        busReady;
    logic        PCEn, regFileWe, aluSrcMuxSel, branch, jal, jalr;
    logic        busReq, busWe, busErr, illegal;
    logic [3:0]  aluControl;
    logic [2:0]  RFWDSrcMuxSel, busSize;

    always #5 clk = ~clk;

    rv32_multicycle_ctrl #(.BUS_WAIT_MAX(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .instrCode     (instrCode),
        .PCEn          (PCEn),
        .regFileWe     (regFileWe),
        .aluSrcMuxSel  (aluSrcMuxSel),
        .aluControl    (aluControl),
        .RFWDSrcMuxSel (RFWDSrcMuxSel),
        .branch        (branch),
        .jal           (jal),
        .jalr          (jalr),
        .busReq        (busReq),
        .busWe         (busWe),
        .busSize       (busSize),
        .busReady      (busReady),
        .busErr        (busErr),
        .illegal       (illegal)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] cur;
    logic [19:0] obs;
    logic [19:0] z_vec, f_vec;

    assign obs = {PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel,
                  branch, jal, jalr, busReq, busWe, busSize, busErr, illegal};

    function automatic logic [19:0] ov(input logic pcen, we, src, input logic [3:0] alu,
                                       input logic [2:0] rfwd, input logic br, jl, jr, req, bwe,
                                       input logic [2:0] size, input logic err, ill);
        return {pcen, we, src, alu, rfwd, br, jl, jr, req, bwe, size, err, ill};
    endfunction

    task automatic chk(input string tag, input logic [19:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    // New cycle: inputs change 1 ns after the edge, outputs sampled on the falling edge
    task automatic cyc(input logic rdy);
        @(posedge clk);
        #1;
        instrCode = cur;
        busReady  = rdy;
        @(negedge clk);
    endtask

    task automatic simple(input string tag, input logic [31:0] ins, input logic [19:0] exe);
        cur = ins;
        cyc(1'b0);
        chk({tag, "_fetch"}, f_vec);
        cyc(1'b0);
        chk({tag, "_decode"}, z_vec);
        cyc(1'b0);
        chk({tag, "_exe"}, exe);
        $display("txn %-6s instr=%08h exe=%05h", tag, ins, obs);
    endtask

    initial begin
        z_vec     = '0;
        f_vec     = ov(1, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        reset     = 1'b1;
        busReady  = 1'b1;
        cur       = 32'h002081B3;
        instrCode = cur;
        repeat (2) @(negedge clk);
        chk("reset", z_vec);

        @(posedge clk);
        #1;
        reset    = 1'b0;
        busReady = 1'b0;
        @(negedge clk);
        chk("add_fetch", f_vec);
        cyc(1'b0);
        chk("add_decode", z_vec);
        cyc(1'b0);
        chk("add_exe", ov(0, 1, 0, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        $display("txn add    instr=%08h exe=%05h", cur, obs);

        simple("sub",   32'h402081B3, ov(0, 1, 0, 4'b1000, 3'd0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        simple("srai",  32'h40315093, ov(0, 1, 1, 4'b1101, 3'd0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        simple("addim", 32'hFFF00093, ov(0, 1, 1, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        simple("bne",   32'h00209463, ov(0, 0, 0, 4'b0001, 3'd0, 1, 0, 0, 0, 0, 3'b000, 0, 0));
        simple("lui",   32'h123452B7, ov(0, 1, 0, 4'b0000, 3'd2, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        simple("auipc", 32'h00001297, ov(0, 1, 0, 4'b0000, 3'd3, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        simple("jal",   32'h010000EF, ov(0, 1, 0, 4'b0000, 3'd4, 0, 1, 0, 0, 0, 3'b000, 0, 0));
        simple("jalr",  32'h000100E7, ov(0, 1, 0, 4'b0000, 3'd4, 0, 1, 1, 0, 0, 3'b000, 0, 0));

        // LW: three wait cycles, ready on the 4th MEM cycle (also the timeout cycle)
        simple("lw",    32'h0080A283, ov(0, 0, 1, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3);
            chk("lw_mem", ov(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 1, 0, 3'b010, 0, 0));
        end
        cyc(1'b0);
        chk("lw_wb", ov(0, 1, 0, 4'b0000, 3'd1, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        $display("txn lw     4 mem cycles, wb=%05h", obs);

        // SW: single-cycle transfer; busReady left high into FETCH is ignored
        simple("sw",    32'h0050A623, ov(0, 0, 1, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        cyc(1'b1);
        chk("sw_mem", ov(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 1, 1, 3'b010, 0, 0));
        $display("txn sw     mem=%05h", obs);

        // LB: busReady never arrives, timeout on the 4th MEM cycle
        cur = 32'h00008283;
        cyc(1'b1);
        chk("lb_fetch", f_vec);
        cyc(1'b0);
        chk("lb_decode", z_vec);
        cyc(1'b0);
        chk("lb_exe", ov(0, 0, 1, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0);
            chk("lb_mem", ov(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 1, 0, 3'b000, i == 3, 0));
        end
        cur = 32'h0080A283;
        cyc(1'b0);
        chk("lb_to_fetch", f_vec);
        $display("txn lb     timed out, back to fetch");

        // LW interrupted by reset while busReq is high
        cyc(1'b0);
        chk("lwr_decode", z_vec);
        cyc(1'b0);
        chk("lwr_exe", ov(0, 0, 1, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        cyc(1'b0);
        chk("lwr_mem", ov(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 1, 0, 3'b010, 0, 0));
        #1;
        reset     = 1'b1;
        cur       = 32'h0000007F;
        instrCode = cur;
        #1;
        chk("rst_mid", z_vec);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ill_fetch", f_vec);
        $display("txn rst    mid-transfer reset, restart at fetch");

        cyc(1'b0);
        chk("ill_decode", z_vec);
        cyc(1'b0);
`ifdef CU_ILLEGAL_TRAP_EN
        chk("ill_trap", ov(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 3'b000, 0, 1));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            chk("ill_sticky", ov(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 3'b000, 0, 1));
        end
        $display("txn ill    trapped, illegal=%0b PCEn=%0b", illegal, PCEn);
`else
        chk("ill_nop", z_vec);
        $display("txn ill    treated as nop");
        simple("add2",  32'h002081B3, ov(0, 1, 0, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
